stream_input_adapter: RTL

- Ingress counterpart of the Dilithium output streaming path: accepts the host AXI-Stream-like word stream (valid/ready/last) and forwards it to the Dilithium core through a small first-word-fall-through FIFO.
- Checks the stream length against a per-operation minimum derived from mode/sec_lvl.
- Reports completion or a framing error.

---
 rtl/stream_input_adapter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/stream_input_adapter.sv
// Host-to-Dilithium ingress adapter: valid/ready/last stream into a FWFT FIFO with per-operation length checks.
// Define STREAM_IN_WORDCOUNT_EN to expose the accepted-word counter on word_count.
module stream_input_adapter #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [2:0]       sec_lvl,
    input  logic             valid_i,
    output logic             ready_i,
    input  logic [W-1:0]     data_i,
    input  logic             last_i,
    output logic             dilithium_valid_i,
    input  logic             dilithium_ready_i,
    output logic [W-1:0]     dilithium_data_i,
    output logic             dilithium_last_i,
    output logic             done,
`ifdef STREAM_IN_WORDCOUNT_EN
    output logic [CNT_W-1:0] word_count,
`endif
    output logic             error
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_min_words;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_count;
    logic [W:0]       r_mem [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_read;
    logic             w_flush;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_min_words;

    assign w_full    = (r_count == OW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_accept  = (r_state == S_RECV) && !start && valid_i && !w_full;
    assign w_read    = dilithium_ready_i && !w_empty;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    // Minimum stream length for the operation being started (unknown levels behave as level 5)
    always_comb begin
        w_min_words = CNT_W'(4);
        case (mode)
            2'd1: begin
                case (sec_lvl)
                    3'd2:    w_min_words = CNT_W'(316);
                    3'd3:    w_min_words = CNT_W'(500);
                    default: w_min_words = CNT_W'(608);
                endcase
            end
            2'd2: begin
                case (sec_lvl)
                    3'd2:    w_min_words = CNT_W'(467);
                    3'd3:    w_min_words = CNT_W'(656);
                    default: w_min_words = CNT_W'(899);
                endcase
            end
            default: w_min_words = CNT_W'(4);
        endcase
    end

    // Next-state logic; start overrides every state and flushes the FIFO
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        if (start) begin
            w_flush     = 1'b1;
            w_state_nxt = (mode == 2'd3) ? S_ERR : S_RECV;
        end else begin
            case (r_state)
                S_RECV: begin
                    if (w_accept) begin
                        if (last_i && (w_cnt_inc < r_min_words)) begin
                            w_state_nxt = S_ERR;
                            w_flush     = 1'b1;
                        end else if ((r_mode == 2'd0) && (w_cnt_inc == CNT_W'(4)) && !last_i) begin
                            w_state_nxt = S_ERR;
                            w_flush     = 1'b1;
                        end else if (last_i) begin
                            w_state_nxt = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_min_words <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                r_mode      <= mode;
                r_min_words <= w_min_words;
                r_cnt       <= '0;
            end else if (w_accept) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // FIFO pointers; pointer width matches the power-of-two depth so wrap is natural
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_accept, w_read})
                2'b10:   r_count <= r_count + OW'(1);
                2'b01:   r_count <= r_count - OW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {last_i, data_i};
        end
    end

    assign ready_i           = (r_state == S_RECV) && !w_full && !start;
    assign dilithium_valid_i = !w_empty;
    assign dilithium_data_i  = r_mem[r_rd_ptr][W-1:0];
    assign dilithium_last_i  = !w_empty && r_mem[r_rd_ptr][W];
    assign done              = (r_state == S_DONE);
    assign error             = (r_state == S_ERR);
`ifdef STREAM_IN_WORDCOUNT_EN
    assign word_count        = r_cnt;
`endif

endmodule
